// File: rtl/neuron_mac_sequencer.sv
// Sequencer and saturating MAC for one fully connected neuron: streams activations,
// drives the weight ROM read port in lockstep, adds the bias and hands off the sum.
module neuron_mac_sequencer #(
  parameter int numWeight    = 30,
  parameter int addressWidth = $clog2(numWeight),
  parameter int dataWidth    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          x_valid,
  input  logic signed [dataWidth-1:0]   x_in,
  output logic                          x_ready,
  output logic                          w_ren,
  output logic [addressWidth-1:0]       w_radd,
  input  logic signed [dataWidth-1:0]   w_dout,
  input  logic signed [dataWidth-1:0]   bias,
  output logic signed [2*dataWidth-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int AccW = 2 * dataWidth;
  localparam logic [addressWidth-1:0] LastIdx = addressWidth'(numWeight - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, BIAS, DONE} state_t;

  state_t                   state, state_nxt;
  logic [addressWidth-1:0]  cnt;
  logic                     accept;
  logic signed [dataWidth-1:0] x_q_p0;
  logic                     vld_p0;
  logic signed [AccW-1:0]   acc_p1;
  logic signed [AccW-1:0]   prod_p0;
  logic signed [AccW:0]     mac_sum;
  logic signed [AccW:0]     bias_sum;

  // Clamp a one-bit-wider sum back into the signed accumulator range.
  function automatic logic signed [AccW-1:0] sat(input logic signed [AccW:0] s);
    if (s[AccW] != s[AccW-1])
      return s[AccW] ? {1'b1, {(AccW-1){1'b0}}} : {1'b0, {(AccW-1){1'b1}}};
    return s[AccW-1:0];
  endfunction

  assign prod_p0  = x_q_p0 * w_dout;
  assign mac_sum  = {acc_p1[AccW-1], acc_p1} + {prod_p0[AccW-1], prod_p0};
  assign bias_sum = {acc_p1[AccW-1], acc_p1} + {{(AccW+1-dataWidth){bias[dataWidth-1]}}, bias};

  assign w_radd   = cnt;
  assign out_data = (state == DONE) ? acc_p1 : '0;

  always_comb begin
    state_nxt = state;
    x_ready   = 1'b0;
    accept    = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        x_ready = 1'b1;
        accept  = x_valid && !abort;
        if (abort)
          state_nxt = IDLE;
        else if (x_valid && cnt == LastIdx)
          state_nxt = DRAIN;
      end
      DRAIN: state_nxt = abort ? IDLE : BIAS;
      BIAS:  state_nxt = abort ? IDLE : DONE;
      DONE: begin
        out_valid = 1'b1;
        if (abort || out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign w_ren = accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      x_q_p0 <= '0;
      vld_p0 <= 1'b0;
      acc_p1 <= '0;
    end else begin
      state <= state_nxt;
      // Stage 0: capture the accepted activation; its weight arrives next cycle.
      vld_p0 <= accept;
      if (accept) begin
        x_q_p0 <= x_in;
        cnt    <= cnt + addressWidth'(1);
      end
      // Leaving to IDLE rewinds the address so the ROM port rests at 0.
      if (state != IDLE && state_nxt == IDLE)
        cnt <= '0;
      // Stage 1: saturating accumulate of the product, then the bias.
      if (state == IDLE && start) begin
        cnt    <= '0;
        acc_p1 <= '0;
      end else if (vld_p0) begin
        acc_p1 <= sat(mac_sum);
      end else if (state == BIAS && !abort) begin
        acc_p1 <= sat(bias_sum);
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed bench for neuron_mac_sequencer: a saturating-sum reference model plus
// per-cycle output checks and literal expectations per scenario.
module tb_neuron_mac_sequencer;
  localparam int N = 30;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, x_valid = 1'b0, out_ready = 1'b1;
  logic signed [15:0] x_in = '0, w_dout = '0, bias = '0;
  logic x_ready, w_ren, out_valid, busy;
  logic [4:0] w_radd;
  logic signed [31:0] out_data;

  logic signed [15:0] wrom [N];
  logic signed [15:0] xs [N];
  int errors = 0, checks = 0, cyc = 0, exp_addr = 0;
  logic expect_out = 1'b0;
  logic signed [31:0] exp_out = '0;

  neuron_mac_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .x_valid(x_valid), .x_in(x_in),
    .x_ready(x_ready), .w_ren(w_ren), .w_radd(w_radd), .w_dout(w_dout), .bias(bias),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Weight ROM with one-cycle registered read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (w_ren && int'(w_radd) < N) w_dout <= wrom[int'(w_radd)];
  end

  task automatic chk(input string name, input logic ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic longint clamp(input longint a);
    if (a > 64'sd2147483647) return 64'sd2147483647;
    if (a < -64'sd2147483648) return -64'sd2147483648;
    return a;
  endfunction

  function automatic longint model();
    longint a;
    a = 0;
    for (int i = 0; i < N; i++) a = clamp(a + longint'(xs[i]) * longint'(wrom[i]));
    return clamp(a + longint'(bias));
  endfunction

  // Every-cycle comparison against the model and the idle-state output values.
  always @(negedge clk) begin
    if (w_ren) begin
      chk("w_radd_seq", w_radd == 5'(exp_addr) && x_valid, longint'(w_radd), longint'(exp_addr));
      exp_addr++;
    end
    if (out_valid)
      chk("out_data_model", expect_out && out_data == exp_out, longint'(out_data), longint'(exp_out));
    if (!busy)
      chk("idle_outputs", !x_ready && !w_ren && w_radd == 5'd0 && !out_valid && out_data == 32'sd0,
          longint'({x_ready, w_ren, out_valid, w_radd, out_data}), 0);
  end

  task automatic setup(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0: begin wrom[i] = 16'sh0001; xs[i] = 16'(i + 1); end
        1: begin wrom[i] = (i % 2 == 0) ? 16'shFFFF : 16'sh0001; xs[i] = 16'sh7FFF; end
        2: begin wrom[i] = 16'sh8000; xs[i] = 16'sh8000; end
        default: begin wrom[i] = 16'sh8000; xs[i] = 16'sh7FFF; end
      endcase
    end
    case (kind)
      0: bias = 16'sd5;
      1: bias = 16'shFFFE;
      2: bias = 16'sh7FFF;
      default: bias = 16'sd0;
    endcase
  endtask

  task automatic run(input string name, input int gap, input int abort_at, input int rst_at,
                     input int hold, input longint lit);
    int t0, lat;
    logic seen;
    longint m;
    m = model();
    chk({name, "_model_lit"}, m == lit, m, lit);
    exp_out = 32'(m);
    exp_addr = 0;
    expect_out = 1'b0;
    out_ready = (hold != 0) ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gap != 0 && i > 0) begin
        x_valid = 1'b0;
        @(posedge clk); #1;
      end
      x_valid = 1'b1;
      x_in = xs[i];
      if (i + 1 == abort_at) abort = 1'b1;
      if (i + 1 == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      if (abort || rst) begin
        abort = 1'b0;
        x_valid = 1'b0;
        @(negedge clk);
        chk({name, "_interrupt_idle"}, !busy && !out_valid && out_data == 32'sd0 && w_radd == 5'd0,
            longint'({busy, out_valid, w_radd}), 0);
        rst = 1'b0;
        return;
      end
    end
    x_valid = 1'b0;
    expect_out = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk({name, "_out_valid_seen"}, seen, longint'(seen), 1);
    if (seen) begin
      lat = cyc - t0;
      chk({name, "_latency"}, lat == ((gap != 0) ? 62 : 33), lat, (gap != 0) ? 62 : 33);
      chk({name, "_out_lit"}, out_data == 32'(lit), longint'(out_data), lit);
      if (hold != 0) begin
        for (int k = 0; k < 5; k++) begin
          start = (k % 2 == 0);
          @(posedge clk); #1;
          start = 1'b0;
          @(negedge clk);
          chk({name, "_hold"}, out_valid && busy && out_data == 32'(lit), longint'(out_data), lit);
        end
        out_ready = 1'b1;
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk({name, "_one_cycle"}, !out_valid && !busy, longint'({out_valid, busy}), 0);
    end
    expect_out = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_values", !x_ready && !w_ren && w_radd == 5'd0 && !out_valid && out_data == 32'sd0 && !busy,
        longint'({x_ready, w_ren, w_radd, out_valid, busy}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    setup(0); run("ones", 0, 0, 0, 0, 470);
    setup(0); run("ones_gap", 1, 0, 0, 0, 470);
    setup(1); run("alt_sign", 0, 0, 0, 0, -2);
    setup(2); run("sat_pos", 0, 0, 0, 0, 64'sd2147483647);
    setup(3); run("sat_neg", 0, 0, 0, 0, -64'sd2147483648);
    setup(0); run("hold_done", 0, 0, 0, 1, 470);
    setup(0); run("abort10", 0, 10, 0, 0, 470);
    setup(0); run("after_abort", 0, 0, 0, 0, 470);
    setup(0); run("rst20", 0, 0, 20, 0, 470);
    setup(0); run("after_rst", 0, 0, 0, 0, 470);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/neuron_mac_sequencer.md
# neuron_mac_sequencer

Controller and accumulator for one fully connected neuron. It streams a layer's input activations, sequences the read port of that neuron's weight ROM (ren/radd, 1-cycle read latency) in lockstep, and accumulates the signed products with saturation. It then adds the neuron bias and presents the pre-activation sum to the activation stage through a valid/ready handshake. One instance sits beside each weight memory in a layer.

## Interface
- numWeight, 30, weights and inputs per neuron.
- addressWidth, $clog2(numWeight), weight ROM address width.
- dataWidth, 16, width of activation, weight and bias (signed two's complement).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  begin a new neuron evaluation; honoured only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE next edge, no output.
- x_valid  in  1  input activation valid.
- x_in  in  dataWidth  input activation.
- x_ready  out  1  sequencer accepts x_in.
- w_ren  out  1  weight ROM read enable.
- w_radd  out  addressWidth  weight ROM read address.
- w_dout  in  dataWidth  weight ROM registered read data.
- bias  in  dataWidth  neuron bias; sampled in the BIAS state.
- out_data  out  2*dataWidth  saturated pre-activation sum.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, RUN, DRAIN, BIAS, DONE.
- IDLE:
  - start=1 clears the accumulator and the input counter cnt, then moves to RUN.
- RUN:
  - x_ready=1.
  - An accept is x_valid & x_ready. On an accept:
    - w_ren=1 and w_radd=cnt (combinational, same cycle).
    - x_in is registered into x_q, and p_valid is set for the next cycle.
    - cnt increments.
  - The accept with cnt==numWeight-1 moves the state to DRAIN.
- Pipeline stage: in any cycle with p_valid=1, acc <= sat(acc + x_q*w_dout).
  - The product is a signed dataWidth×dataWidth multiply giving 2*dataWidth bits.
  - The sum is formed at 2*dataWidth+1 bits and clamped to the signed 2*dataWidth range [0x80000000, 0x7FFFFFFF] at default width.
- DRAIN: x_ready=0. Completes the last product, then moves to BIAS.
- BIAS: acc <= sat(acc + sign_extend(bias)), then moves to DONE.
- DONE: out_valid=1 and out_data=acc, held stable until out_ready=1, then moves to IDLE.
- w_radd equals cnt at all times; it reads 0 in IDLE.
- w_ren is never asserted outside RUN.
- start is ignored in RUN, DRAIN, BIAS and DONE. A start in the same cycle as a DONE handshake is also ignored.
- abort has priority over all other inputs in every non-IDLE state:
  - The next state is IDLE, p_valid is cleared and out_valid stays 0.
  - acc is not cleared until the next start.
- rst clears the state to IDLE and clears cnt, acc, x_q and p_valid. It takes effect immediately, including mid-run.

## Timing
- Reset values: x_ready=0, w_ren=0, w_radd=0, out_valid=0, out_data=0, busy=0.
- Start cycle T (state IDLE): RUN starts at T+1.
- With x_valid held high, the accepts fall in cycles T+1 through T+numWeight.
- Weight data for an accept in cycle t is valid on w_dout in cycle t+1; acc is updated at the end of t+1.
- Last accept in cycle L: DRAIN is cycle L+1, BIAS is cycle L+2, and out_valid rises in cycle L+3.
- The minimum time from start to out_valid is numWeight+3 cycles (T+33 at default).
- Gaps in x_valid stall cnt and leave acc unchanged. There is no timeout.
- busy rises the cycle after start is accepted and falls the cycle after the DONE handshake.

## Test plan
- All weights 0x0001, x=1..30 back-to-back, bias=5, out_ready=1:
  - out_data=470 in cycle T+33 for exactly one cycle.
  - w_radd sequence is 0..29.
- Same stimulus with x_valid toggling 1,0,1,0:
  - out_data=470.
  - w_ren pulses only on accepts, and w_radd never skips or repeats.
- Weights alternating 0xFFFF/0x0001, x=0x7FFF for all 30 inputs, bias=0xFFFE:
  - out_data=0xFFFFFFFE (-2).
- Weights and x all 0x8000 (product 2^30), bias=0x7FFF:
  - acc saturates to 0x7FFFFFFF and stays there.
  - A second run with weights 0x8000 and x=0x7FFF saturates to 0x80000000.
- out_ready held 0 for 5 cycles in DONE:
  - out_valid and out_data hold stable, and start pulses are ignored.
  - out_ready=1 returns the block to IDLE.
- abort at the 10th accept, and rst asserted at the 20th accept:
  - Both return to IDLE with out_valid=0 and outputs at reset values.
  - The next full run gives a correct sum with no residue from the interrupted run.
